// File: rtl/cart_map_pkg.sv
// Shared types and constants for the HuCard-to-PSRAM bank mapper.
package cart_map_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_HOLD,
      WR,
      WR_END
   } state_t;

   localparam int A20_BIT = 20;
   localparam int A19_BIT = 19;

   // Field split for the default four-slot build; other builds derive theirs the same way.
   localparam int NUM_BANKS_DEF = 4;
   localparam int IDX_W         = $clog2(NUM_BANKS_DEF);
   localparam int SLOT_LSB      = A19_BIT - IDX_W;

   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/strobe_sync.sv
// Synchroniser for an active-low bus strobe with a one-cycle falling-edge pulse.
module strobe_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   output logic synced,
   output logic fall
);

   logic [STAGES-1:0] chain_p0;
   logic              prev_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_p0 <= '1;
         prev_p1  <= 1'b1;
      end else begin
         chain_p0 <= {chain_p0[STAGES-2:0], strobe};
         prev_p1  <= chain_p0[STAGES-1];
      end
   end

   assign synced = chain_p0[STAGES-1];
   assign fall   = prev_p1 & ~chain_p0[STAGES-1];

endmodule

// File: rtl/cart_bank_mapper.sv
// HuCard bus to PSRAM mapper with SF2-style banking of the upper 512 KB window.
module cart_bank_mapper
   import cart_map_pkg::*;
#(
   parameter int          NUM_BANKS   = 4,
   parameter int          BANK_W      = 6,
   parameter logic [12:0] REG_BASE    = 13'h1FF0,
   parameter int          SYNC_STAGES = 2,
   parameter int          RD_CYC      = 3,
   parameter int          WR_CYC      = 4,
   parameter int          ROM_WR_EN   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [20:0] cpu_addr,
   input  logic [7:0]  cpu_data_i,
   output logic [7:0]  cpu_data_o,
   output logic        cpu_data_oe,
   input  logic        cpu_oe,
   input  logic        cpu_we,
   input  logic        region,
   output logic [21:0] ram_addr,
   input  logic [15:0] ram_di,
   output logic [15:0] ram_do,
   output logic        ram_dq_oe,
   output logic        ram_ce,
   output logic        ram_oe,
   output logic        ram_we,
   output logic        ram_ub,
   output logic        ram_lb,
   output logic        map_wr,
   output logic        busy
);

   localparam int MAP_IDX_W    = $clog2(NUM_BANKS);
   localparam int MAP_SLOT_LSB = A19_BIT - MAP_IDX_W;
   localparam int WORD_W       = BANK_W + MAP_SLOT_LSB - 1;

   state_t              state, state_n;
   logic [3:0]          cnt, cnt_n;
   logic [19:0]         addr_q, addr_n;
   logic [7:0]          data_q, data_in, rd_byte;
   logic [BANK_W-1:0]   bank [NUM_BANKS];
   logic                oe_sync, we_sync, oe_fall, we_fall;
   logic                idle_req, reg_hit, start_rd, start_wr, reg_wr, capture;
   logic                wr_first_n, lane_on_n;
   logic [MAP_IDX_W-1:0] slot, reg_idx;

   strobe_sync #(.STAGES(SYNC_STAGES)) u_oe_sync (
      .clk(clk), .rst(rst), .strobe(cpu_oe), .synced(oe_sync), .fall(oe_fall)
   );

   strobe_sync #(.STAGES(SYNC_STAGES)) u_we_sync (
      .clk(clk), .rst(rst), .strobe(cpu_we), .synced(we_sync), .fall(we_fall)
   );

   assign data_in  = region ? bit_rev8(cpu_data_i) : cpu_data_i;
   assign reg_hit  = cpu_addr[12:MAP_IDX_W] == REG_BASE[12:MAP_IDX_W];
   assign reg_idx  = cpu_addr[MAP_IDX_W-1:0];
   assign idle_req = (state == IDLE) && !cpu_addr[A20_BIT];
   // A read edge wins over a simultaneous write edge, so writes are gated by !oe_fall.
   assign start_rd = idle_req && oe_fall;
   assign reg_wr   = idle_req && we_fall && !oe_fall && reg_hit;
   assign start_wr = idle_req && we_fall && !oe_fall && !reg_hit && (ROM_WR_EN != 0);
   assign addr_n   = (start_rd || start_wr) ? cpu_addr[19:0] : addr_q;

   assign slot    = addr_q[A19_BIT-1 -: MAP_IDX_W];
   assign rd_byte = addr_q[0] ? ram_di[7:0] : ram_di[15:8];
   assign ram_do  = {data_q, data_q};

   always_comb begin
      ram_addr = '0;
      if (addr_q[A19_BIT]) begin
         ram_addr[WORD_W-1:0] = {bank[slot], addr_q[MAP_SLOT_LSB-1:1]};
      end else begin
         ram_addr[17:0] = addr_q[18:1];
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      capture = 1'b0;
      case (state)
         IDLE: begin
            if (start_rd) begin
               state_n = RD;
               cnt_n   = '0;
            end else if (start_wr) begin
               state_n = WR;
               cnt_n   = '0;
            end
         end
         RD: begin
            if (cnt == 4'(RD_CYC - 1)) begin
               state_n = RD_HOLD;
               capture = 1'b1;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         RD_HOLD: begin
            if (oe_sync) state_n = IDLE;
         end
         WR: begin
            if (cnt == 4'(WR_CYC - 1)) begin
               state_n = WR_END;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         WR_END: begin
            // cnt==0 marks the single data-hold cycle after ram_we rises.
            if (cnt == '0) begin
               cnt_n = 4'd1;
            end else if (we_sync) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign wr_first_n = (state_n == WR_END) && (cnt_n == '0);
   assign lane_on_n  = (state_n == RD) || (state_n == WR) || wr_first_n;

   // Control outputs are registered from next-state so they change cleanly on the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         cpu_data_o  <= '0;
         cpu_data_oe <= 1'b0;
         ram_dq_oe   <= 1'b0;
         ram_ce      <= 1'b1;
         ram_oe      <= 1'b1;
         ram_we      <= 1'b1;
         ram_ub      <= 1'b1;
         ram_lb      <= 1'b1;
         map_wr      <= 1'b0;
         busy        <= 1'b0;
         for (int k = 0; k < NUM_BANKS; k++) begin
            bank[k] <= BANK_W'(NUM_BANKS + k);
         end
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         addr_q <= addr_n;
         if (start_wr) data_q <= data_in;
         if (reg_wr) bank[reg_idx] <= data_in[BANK_W-1:0];
         if (capture) cpu_data_o <= region ? bit_rev8(rd_byte) : rd_byte;
         cpu_data_oe <= (state_n == RD_HOLD) && !oe_sync;
         ram_dq_oe   <= (state_n == WR) || wr_first_n;
         ram_ce      <= !lane_on_n;
         ram_oe      <= !(state_n == RD);
         ram_we      <= !(state_n == WR);
         ram_ub      <= !(lane_on_n && !addr_n[0]);
         ram_lb      <= !(lane_on_n && addr_n[0]);
         map_wr      <= reg_wr;
         busy        <= state_n != IDLE;
      end
   end

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Randomised self-checking bench for cart_bank_mapper against a bank-table reference model.
module tb_cart_bank_mapper;

   localparam int RD_CYC = 3;
   localparam int WR_CYC = 4;
   localparam int SYNC   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [20:0] cpu_addr = '0;
   logic [7:0]  cpu_data_i = '0;
   logic        cpu_oe = 1'b1;
   logic        cpu_we = 1'b1;
   logic        region = 1'b0;
   logic [15:0] ram_di = '0;

   logic [7:0]  cpu_data_o;
   logic        cpu_data_oe, ram_dq_oe, ram_ce, ram_oe, ram_we, ram_ub, ram_lb, map_wr, busy;
   logic [21:0] ram_addr;
   logic [15:0] ram_do;

   logic [7:0]  ro_cpu_data_o;
   logic        ro_cpu_data_oe, ro_ram_dq_oe, ro_ram_ce, ro_ram_oe, ro_ram_we, ro_ram_ub, ro_ram_lb;
   logic        ro_map_wr, ro_busy;
   logic [21:0] ro_ram_addr;
   logic [15:0] ro_ram_do;

   int n_cmp = 0;
   int n_err = 0;
   int bank_m [4];

   always #10 clk = ~clk;

   cart_bank_mapper #(.ROM_WR_EN(1)) dut (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i),
      .cpu_data_o(cpu_data_o), .cpu_data_oe(cpu_data_oe), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
      .region(region), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
      .ram_dq_oe(ram_dq_oe), .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we),
      .ram_ub(ram_ub), .ram_lb(ram_lb), .map_wr(map_wr), .busy(busy)
   );

   cart_bank_mapper #(.ROM_WR_EN(0)) dut_ro (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i),
      .cpu_data_o(ro_cpu_data_o), .cpu_data_oe(ro_cpu_data_oe), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
      .region(region), .ram_addr(ro_ram_addr), .ram_di(ram_di), .ram_do(ro_ram_do),
      .ram_dq_oe(ro_ram_dq_oe), .ram_ce(ro_ram_ce), .ram_oe(ro_ram_oe), .ram_we(ro_ram_we),
      .ram_ub(ro_ram_ub), .ram_lb(ro_ram_lb), .map_wr(ro_map_wr), .busy(ro_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rev8(input int b);
      int v = b;
      int r = 0;
      for (int i = 0; i < 8; i++) begin
         r = r * 2 + v % 2;
         v = v / 2;
      end
      return r;
   endfunction

   function automatic int exp_word(input int a);
      int phys;
      if ((a / 524288) % 2 == 1) phys = bank_m[(a / 131072) % 4] * 131072 + a % 131072;
      else phys = a % 524288;
      return phys / 2;
   endfunction

   function automatic bit is_reg(input int a);
      return (a / 1048576) % 2 == 0 && (a % 8192) / 4 == 'h1FF0 / 4;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) bank_m[k] = 4 + k;
   endtask

   task automatic do_read(input int a, input logic rg, input int di, input logic both);
      int oe_low = 0, ce_low = 0, first = 0, bad_oe = 0, busy_seen = 0, mw = 0, we_low = 0;
      int released = 0, got_addr = 0, got_ub = 1, got_lb = 1, got_data = 0, eb;
      bit active = (a / 1048576) % 2 == 0;
      @(negedge clk);
      cpu_addr = 21'(a);
      region   = rg;
      ram_di   = 16'(di);
      cpu_oe   = 1'b0;
      if (both) cpu_we = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (!ram_oe) begin
            if (oe_low == 0) begin
               got_addr = int'(ram_addr);
               got_ub   = int'(ram_ub);
               got_lb   = int'(ram_lb);
            end
            oe_low++;
            if (cpu_data_oe) bad_oe++;
         end
         if (!ram_ce) ce_low++;
         if (!ram_we) we_low++;
         if (map_wr || ro_map_wr) mw++;
         if (busy) busy_seen++;
         if (cpu_data_oe && first == 0) begin
            first    = c;
            got_data = int'(cpu_data_o);
         end
      end
      cpu_oe = 1'b1;
      cpu_we = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (!cpu_data_oe && !busy) begin
            released = 1;
            break;
         end
      end
      chk("rd_no_write", mw + we_low, 0);
      chk("rd_release", released, 1);
      if (active) begin
         eb = (a % 2 == 1) ? di % 256 : (di / 256) % 256;
         if (rg) eb = rev8(eb);
         chk("rd_oe_cycles", oe_low, RD_CYC);
         chk("rd_ce_cycles", ce_low, RD_CYC);
         chk("rd_addr", got_addr, exp_word(a));
         chk("rd_ub", got_ub, a % 2);
         chk("rd_lb", got_lb, 1 - a % 2);
         chk("rd_deadline", (first > 0 && first <= SYNC + RD_CYC + 1) ? 1 : 0, 1);
         chk("rd_data", got_data, eb);
         chk("rd_oe_overlap", bad_oe, 0);
      end else begin
         chk("a20_rd_ram", oe_low + ce_low, 0);
         chk("a20_rd_data_oe", first, 0);
         chk("a20_rd_busy", busy_seen, 0);
      end
   endtask

   task automatic do_write(input int a, input logic rg, input int bus);
      int mw = 0, mw_ro = 0, we_low = 0, ce_low = 0, bad_ce = 0, ro_act = 0, dq_after = 0;
      int got_addr = 0, got_do = 0, got_ub = 1, got_lb = 1, got_dq = 0, prev_we = 1, dat;
      @(negedge clk);
      cpu_addr   = 21'(a);
      region     = rg;
      cpu_data_i = 8'(bus);
      cpu_we     = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (map_wr) mw++;
         if (ro_map_wr) mw_ro++;
         if (!ram_ce) ce_low++;
         if (!ram_we) begin
            if (we_low == 0) begin
               got_addr = int'(ram_addr);
               got_do   = int'(ram_do);
               got_ub   = int'(ram_ub);
               got_lb   = int'(ram_lb);
               got_dq   = int'(ram_dq_oe);
            end
            we_low++;
            if (ram_ce) bad_ce++;
         end else if (prev_we == 0) begin
            dq_after = int'(ram_dq_oe);
         end
         prev_we = int'(ram_we);
         if (!ro_ram_ce || !ro_ram_we || ro_ram_dq_oe) ro_act++;
         if (c == 12) cpu_we = 1'b1;
      end
      chk("wr_idle", busy, 0);
      chk("wr_ro_no_ram", ro_act, 0);
      dat = rg ? rev8(bus) : bus;
      if (is_reg(a)) begin
         chk("reg_map_wr", mw, 1);
         chk("reg_map_wr_ro", mw_ro, 1);
         chk("reg_no_ram", we_low + ce_low, 0);
         bank_m[a % 4] = dat % 64;
      end else if ((a / 1048576) % 2 == 0) begin
         chk("rom_no_map_wr", mw, 0);
         chk("rom_we_cycles", we_low, WR_CYC);
         chk("rom_ce_with_we", bad_ce, 0);
         chk("rom_addr", got_addr, exp_word(a));
         chk("rom_do", got_do, dat * 257);
         chk("rom_ub", got_ub, a % 2);
         chk("rom_lb", got_lb, 1 - a % 2);
         chk("rom_dq_oe", got_dq, 1);
         chk("rom_end_dq", dq_after, 1);
      end else begin
         chk("a20_wr_quiet", mw + we_low + ce_low, 0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {ram_ce, ram_oe, ram_we, ram_ub, ram_lb}, 5'b11111);
      chk({tag, "_oe"}, {ram_dq_oe, cpu_data_oe, map_wr, busy}, 4'b0000);
      chk({tag, "_ro"}, {ro_cpu_data_oe, ro_busy}, 2'b00);
   endtask

   initial begin
      int found;
      int a, kind;
      model_reset();
      #2 rst = 1'b1;
      #3;
      check_reset_outputs("reset");
      chk("reset_data_o", cpu_data_o, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      do_read('h80004, 1'b0, 'hB72C, 1'b0);
      do_write('h01FF2, 1'b0, 'h05);
      do_read('hC0010, 1'b0, 'h1234, 1'b0);
      do_write('h01FF1, 1'b1, 'hA0);
      chk("bank1_model", bank_m[1], 5);
      do_read('hA0011, 1'b1, 'h0001, 1'b0);
      do_write('h00101, 1'b0, 'h3C);
      do_read('h100000, 1'b0, 'hFFFF, 1'b0);
      do_write('h101FF0, 1'b0, 'h11);
      do_read('h01FF3, 1'b0, 'h5AC3, 1'b1);

      // Reset in the middle of a PSRAM read.
      @(negedge clk);
      cpu_addr = 21'h80004;
      cpu_oe   = 1'b0;
      found    = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         @(negedge clk);
         if (!ram_oe) found = 1;
      end
      chk("rst_reach_rd", found, 1);
      #3 rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      cpu_oe = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      do_read('hC0000, 1'b0, 'hA55A, 1'b0);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 1) begin
            a = int'($urandom_range(0, 127)) * 8192 + 'h1FF0 + int'($urandom_range(0, 3));
            do_write(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
         end else if (kind <= 3) begin
            a = int'($urandom & 32'h000FFFFF);
            do_write(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
         end else if (kind == 4) begin
            a = int'($urandom & 32'h000FFFFF) + 'h100000;
            do_read(a, 1'b0, int'($urandom_range(0, 65535)), 1'b0);
         end else begin
            a = int'($urandom & 32'h000FFFFF);
            do_read(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
